fifo_ctrl_stat: RTL and testbench

//   Second-generation FIFO pointer/status controller. Drives address and write-enable for an

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ptr.sv | 20 ++
 rtl/fifo_ctrl_stat.sv | 104 ++++++++++
 tb/tb_fifo_ctrl_stat.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: sizing helper and default threshold constants.
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH         = 4;
    localparam int DEF_ALMOST_EMPTY_TH    = 2;
    // almost_full default sits this many entries below DEPTH
    localparam int DEF_ALMOST_FULL_MARGIN = 2;

    // Ceiling log2; clog2(DEPTH+1) gives the width needed to hold 0..DEPTH.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: increments mod 2**ADDR_WIDTH, synchronous clear and reset.
module fifo_ptr #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  inc,
    input  logic                  clr,
    output logic [ADDR_WIDTH-1:0] ptr
);

    // Pointer register; wrap comes for free from the fixed width.
    always_ff @(posedge clk) begin
        if (!reset_n || clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/fifo_ctrl_stat.sv
// FIFO pointer/status controller for an external RAM with combinational read:
// occupancy count, thresholds, flush and sticky overflow/underflow flags.
module fifo_ctrl_stat
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL_TH  = (2 ** ADDR_WIDTH) - DEF_ALMOST_FULL_MARGIN,
    parameter int ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = clog2(DEPTH + 1);

    // Threshold sanity check at elaboration
    initial begin
        if (ALMOST_EMPTY_TH < 1 || ALMOST_EMPTY_TH >= ALMOST_FULL_TH || ALMOST_FULL_TH > DEPTH - 1)
            $error("fifo_ctrl_stat: thresholds out of range (AE=%0d AF=%0d DEPTH=%0d)",
                   ALMOST_EMPTY_TH, ALMOST_FULL_TH, DEPTH);
    end

    logic          rd_acc;
    logic          wr_acc;
    logic          ov_set;
    logic          un_set;
    logic [CW-1:0] count_next;

    // Acceptance from registered state only; a read at full frees the slot the write uses
    always_comb begin
        rd_acc     = rd & ~empty & ~flush;
        wr_acc     = wr & (~full | rd) & ~flush;
        ov_set     = wr & full & ~rd & ~flush;
        un_set     = rd & empty & ~flush;
        count_next = count + CW'(wr_acc) - CW'(rd_acc);
        we         = wr_acc;
    end

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (wr_acc),
        .clr     (flush),
        .ptr     (w_addr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (rd_acc),
        .clr     (flush),
        .ptr     (r_addr)
    );

    // Count and status flags, all derived from count_next so they update together
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == CW'(DEPTH));
            almost_empty <= (count_next <= CW'(ALMOST_EMPTY_TH));
            almost_full  <= (count_next >= CW'(ALMOST_FULL_TH));
        end
    end

    // Sticky errors: set beats clear, flush leaves them alone
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ov_set)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (un_set)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_stat.sv
// Bench for fifo_ctrl_stat: occupancy-level model checked every cycle plus literal checkpoints.
module tb_fifo_ctrl_stat;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF_TH = 14;
    localparam int AE_TH = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr = 1'b0, rd = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic          we;
    logic [AW-1:0] w_addr, r_addr;
    logic [AW:0]   count;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // model state: occupancy and pointer positions as plain integers
    int m_count = 0, m_w = 0, m_r = 0;
    bit m_ov = 0, m_un = 0;

    fifo_ctrl_stat #(.ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .rd           (rd),
        .flush        (flush),
        .err_clr      (err_clr),
        .we           (we),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare at negedge, then advance the model with the inputs the next edge will sample
    always @(negedge clk) begin
        if (started) begin
            bit r_ok, w_ok;
            chk("count", int'(count), m_count);
            chk("w_addr", int'(w_addr), m_w);
            chk("r_addr", int'(r_addr), m_r);
            chk("empty", int'(empty), int'(m_count == 0));
            chk("full", int'(full), int'(m_count == DEPTH));
            chk("almost_empty", int'(almost_empty), int'(m_count <= AE_TH));
            chk("almost_full", int'(almost_full), int'(m_count >= AF_TH));
            chk("overflow", int'(overflow), int'(m_ov));
            chk("underflow", int'(underflow), int'(m_un));
            r_ok = rd && m_count > 0 && !flush;
            w_ok = wr && (m_count < DEPTH || rd) && !flush;
            if (reset_n)
                chk("we", int'(we), int'(w_ok));
            if (!reset_n) begin
                m_count = 0; m_w = 0; m_r = 0; m_ov = 0; m_un = 0;
            end else begin
                if (!flush && wr && m_count == DEPTH && !rd) m_ov = 1;
                else if (err_clr)                            m_ov = 0;
                if (!flush && rd && m_count == 0)            m_un = 1;
                else if (err_clr)                            m_un = 0;
                if (flush) begin
                    m_count = 0; m_w = 0; m_r = 0;
                end else begin
                    m_count = m_count + int'(w_ok) - int'(r_ok);
                    if (w_ok) m_w = (m_w + 1) % DEPTH;
                    if (r_ok) m_r = (m_r + 1) % DEPTH;
                end
            end
        end
    end

    task automatic cyc(input logic w, input logic r, input logic f, input logic e);
        wr = w; rd = r; flush = f; err_clr = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        cyc(0, 0, 0, 0);
        started = 1'b1;
        cyc(0, 0, 0, 0);
        reset_n = 1'b1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_ae", int'(almost_empty), 1);

        // 1: sixteen writes
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 0, 0, 0);
            if (i == 2)  chk("ae_after_2", int'(almost_empty), 1);
            if (i == 3)  chk("ae_after_3", int'(almost_empty), 0);
            if (i == 13) chk("af_after_13", int'(almost_full), 0);
            if (i == 14) chk("af_after_14", int'(almost_full), 1);
        end
        chk("fill_count", int'(count), 16);
        chk("fill_full", int'(full), 1);
        chk("fill_waddr", int'(w_addr), 0);

        // 2: write at full
        cyc(1, 0, 0, 0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 16);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        chk("ovf_sticky", int'(overflow), 1);
        cyc(0, 0, 0, 1);
        chk("ovf_clr", int'(overflow), 0);

        // 3: rd & wr at full for 20 cycles
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0);
        chk("rw_full_count", int'(count), 16);
        chk("rw_full_waddr", int'(w_addr), 4);
        chk("rw_full_raddr", int'(r_addr), 4);
        chk("rw_full_ovf", int'(overflow), 0);

        // 4: drain, then rd & wr at empty
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0);
        chk("drain_empty", int'(empty), 1);
        cyc(1, 1, 0, 0);
        chk("rw_empty_count", int'(count), 1);
        chk("rw_empty_raddr", int'(r_addr), 4);
        chk("rw_empty_unf", int'(underflow), 1);

        // 5: fill, overflow, back down to 9, flush with rd & wr
        for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0);
        chk("pre_flush_count", int'(count), 9);
        wr = 1; rd = 1; flush = 1; err_clr = 0;
        #1;
        chk("flush_we", int'(we), 0);
        @(posedge clk);
        #1;
        chk("flush_count", int'(count), 0);
        chk("flush_waddr", int'(w_addr), 0);
        chk("flush_ovf_kept", int'(overflow), 1);

        // 6: reset mid-stream at count 7
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
        reset_n = 1'b0;
        cyc(1, 1, 0, 0);
        reset_n = 1'b1;
        chk("rst2_count", int'(count), 0);
        chk("rst2_ovf", int'(overflow), 0);
        chk("rst2_unf", int'(underflow), 0);
        cyc(0, 1, 0, 0);
        chk("rst2_rd_unf", int'(underflow), 1);
        cyc(0, 1, 0, 1);
        chk("set_beats_clr", int'(underflow), 1);
        cyc(0, 0, 0, 1);
        chk("unf_clr", int'(underflow), 0);
        cyc(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
